// File: rtl/ctrl_demux_pkg.sv
// ctrl_demux shared types.
// FSM state encoding and drop counter width.
package ctrl_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  localparam int DROP_COUNT_WIDTH = 16;

endpackage

// File: rtl/ctrl_demux_fifo.sv
// ctrl_demux per-port output FIFO, first-word-fall-through.
// Ports: in_* / push write side, out_* / pop read side, full flag.
module ctrl_demux_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic                  push,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  pop,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && out_valid;

  assign {out_last, out_keep, out_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {in_last, in_keep, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_demux.sv
// ctrl_demux: steers whole frames to one of M_COUNT FIFO-backed ports.
// Ports: s_val_axis_* in, s_selector_* per-frame dest, m_val_axis_* out.
module ctrl_demux
  import ctrl_demux_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int M_COUNT        = 2,
  parameter int SELECTOR_WIDTH = $clog2(M_COUNT),
  parameter int KEEP_ENABLE    = 1,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_val_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_val_axis_tkeep,
  input  logic                          s_val_axis_tlast,
  input  logic                          s_val_axis_tvalid,
  output logic                          s_val_axis_tready,
  input  logic [SELECTOR_WIDTH-1:0]     s_selector_tdata,
  input  logic                          s_selector_tvalid,
  output logic                          s_selector_tready,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_val_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_val_axis_tkeep,
  output logic [M_COUNT-1:0]            m_val_axis_tlast,
  output logic [M_COUNT-1:0]            m_val_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_val_axis_tready,
  output logic [15:0]                   drop_count
);

  localparam int SW = SELECTOR_WIDTH;

  state_t                      state;
  state_t                      state_nxt;
  logic [SW-1:0]               sel;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt;
  logic [DROP_COUNT_WIDTH-1:0] drop_nxt;
  logic [M_COUNT-1:0]          full;
  logic [M_COUNT-1:0]          push;
  logic                        last_eff;
  logic [KEEP_WIDTH-1:0]       keep_eff;
  logic                        sel_full;
  logic                        sel_ok;
  logic                        val_ready;
  logic                        sel_ready;
  logic                        beat_ok;
  logic                        drop_done;

  assign last_eff = (KEEP_ENABLE != 0) ? s_val_axis_tlast : 1'b1;
  assign keep_eff = (KEEP_ENABLE != 0) ? s_val_axis_tkeep : '1;

  // Extra bit so M_COUNT == 2**SW still compares correctly.
  assign sel_ok = {1'b0, s_selector_tdata} < (SW + 1)'(M_COUNT);

  always_comb begin
    sel_full = 1'b1;
    for (int i = 0; i < M_COUNT; i++) begin
      if (sel == SW'(i)) begin
        sel_full = full[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    val_ready = 1'b0;
    sel_ready = 1'b0;
    unique case (state)
      IDLE: begin
        sel_ready = s_selector_tvalid;
        if (s_selector_tvalid) begin
          state_nxt = sel_ok ? FWD : DROP;
        end
      end
      FWD: begin
        val_ready = !sel_full;
        if (s_val_axis_tvalid && val_ready && last_eff) begin
          state_nxt = IDLE;
        end
      end
      DROP: begin
        val_ready = 1'b1;
        if (s_val_axis_tvalid && last_eff) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold both readies low while reset is applied.
  assign s_val_axis_tready = val_ready && !rst;
  assign s_selector_tready = sel_ready && !rst;

  assign beat_ok   = s_val_axis_tvalid && s_val_axis_tready;
  assign drop_done = beat_ok && last_eff && (state == DROP);

  always_comb begin
    push = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      push[i] = beat_ok && (state == FWD) && (sel == SW'(i));
    end
  end

  always_comb begin
    drop_nxt = drop_cnt;
    if (drop_done && (drop_cnt != '1)) begin
      drop_nxt = drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (s_selector_tvalid && s_selector_tready) begin
        sel <= s_selector_tdata;
      end
    end
  end

  assign drop_count = drop_cnt;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_port
    ctrl_demux_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_val_axis_tdata),
      .in_keep   (keep_eff),
      .in_last   (last_eff),
      .push      (push[i]),
      .out_data  (m_val_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_keep  (m_val_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]),
      .out_last  (m_val_axis_tlast[i]),
      .out_valid (m_val_axis_tvalid[i]),
      .pop       (m_val_axis_tready[i]),
      .full      (full[i])
    );
  end

endmodule

// File: doc/ctrl_demux.md
Name: ctrl_demux

Overview:
- Upstream companion of the ctrl mux stage. Takes one AXI-Stream value stream and a per-frame selector stream.
- Steers each whole frame to one of M_COUNT output streams, each backed by a shallow output FIFO.
- Its outputs feed per-port value inputs of downstream mux/handler stages.
- Frames with an out-of-range selector are dropped and counted.

Parameters:
- DATA_WIDTH, 16, data bus width in bits.
- M_COUNT, 2, number of output streams (>=2).
- SELECTOR_WIDTH, $clog2(M_COUNT), selector token width.
- KEEP_ENABLE, 1, 1: honour tkeep/tlast; 0: every beat is a single-beat frame.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- FIFO_DEPTH, 4, beats per output FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_val_axis_tdata  in  DATA_WIDTH  input beat data.
- s_val_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_val_axis_tlast  in  1  input end of frame.
- s_val_axis_tvalid  in  1  input beat valid.
- s_val_axis_tready  out  1  input beat accept.
- s_selector_tdata  in  SELECTOR_WIDTH  destination of next frame.
- s_selector_tvalid  in  1  selector valid.
- s_selector_tready  out  1  selector consumed.
- m_val_axis_tdata  out  M_COUNT*DATA_WIDTH  packed output data, port i at [i*DATA_WIDTH +: DATA_WIDTH].
- m_val_axis_tkeep  out  M_COUNT*KEEP_WIDTH  packed output keep.
- m_val_axis_tlast  out  M_COUNT  per-port last.
- m_val_axis_tvalid  out  M_COUNT  per-port valid.
- m_val_axis_tready  in  M_COUNT  per-port ready.
- drop_count  out  16  frames dropped, saturating.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - All FIFOs empty; m_val_axis_tvalid = 0.
  - s_val_axis_tready = 0, s_selector_tready = 0.
  - drop_count = 0.
  - Registered data/keep/last outputs are don't-care while tvalid = 0.
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - s_val_axis_tready = 0.
  - s_selector_tready = s_selector_tvalid (combinational, one-cycle consume).
  - On consume: latch sel = s_selector_tdata.
  - Next state FWD if sel < M_COUNT, else DROP.
- FWD:
  - s_val_axis_tready = !full[sel]. Ready deliberately does not look at a same-cycle pop.
  - Accepted beat is pushed into FIFO[sel].
  - Accepted beat with effective last -> IDLE.
  - s_selector_tready = 0.
- DROP:
  - s_val_axis_tready = 1; beats are discarded.
  - Accepted beat with effective last -> IDLE and drop_count++ (saturates at 16'hFFFF).
- Effective last = KEEP_ENABLE ? s_val_axis_tlast : 1.
- Effective keep = KEEP_ENABLE ? s_val_axis_tkeep : all ones.
- Frame gap: one bubble cycle per frame (the IDLE cycle). Peak throughput for a frame of N beats is N/(N+1).
- Selector ordering: the selector is consumed at frame start, before any data beat of that frame. A selector arriving during FWD/DROP waits until IDLE.
- Output FIFO (per port):
  - Storage FIFO_DEPTH entries, wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits with natural wrap.
  - count 0..FIFO_DEPTH; full = (count == FIFO_DEPTH); m_val_axis_tvalid[i] = (count != 0).
  - Output is first-word-fall-through from storage.
  - Latency: a beat accepted at input in cycle N is visible at output in cycle N+1.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop when empty: ignored. Push when full: cannot occur (ready low).
- Ordering: beat order is preserved per port; frames are never interleaved on a port.
- Reset mid-frame:
  - The partial frame is discarded and all FIFOs are flushed.
  - Upstream resends from a frame boundary; the block drops no beats after reset deasserts.
- Selector stall: the block waits in IDLE indefinitely with s_val_axis_tready = 0.

Decomposition:
- Package ctrl_demux_pkg: state enum (IDLE, FWD, DROP) and DROP_COUNT_WIDTH = 16.
- Sub-module ctrl_demux_fifo:
  - Single-port-in/single-port-out FIFO with pointers and count.
  - Parameters DATA_WIDTH, KEEP_WIDTH, DEPTH.
  - Instantiated M_COUNT times in a generate loop.
- The top level holds the FSM, sel register, drop counter and ready/valid steering.

Test Plan:
- Reset, then selector=1 with a 3-beat frame (0xA1,0xA2,0xA3 with last on beat 3), all m ready=1 -> port 1 emits the three beats in order, the first one cycle after its accept; port 0 tvalid stays 0; drop_count=0.
- Selectors 0,1,0 back-to-back with 2-beat frames -> each port receives its frames intact and in order; exactly one IDLE bubble between frames; s_selector_tready pulses once per frame.
- Backpressure: m_val_axis_tready[0]=0, selector=0, 6-beat frame, FIFO_DEPTH=4 -> 4 beats accepted, then s_val_axis_tready=0. Release ready -> all 6 beats are delivered, none are lost or duplicated.
- Out-of-range: M_COUNT=3, selector=3, 2-beat frame -> beats are accepted and discarded, no m tvalid rises, drop_count=1. Repeat 65537 times (forced) -> drop_count saturates at 16'hFFFF.
- KEEP_ENABLE=0: selectors 1,0 with single beats 0x55,0x66 (tlast held 0) -> each beat is treated as a frame; outputs tkeep=2'b11 and tlast=1.
- Assert rst during beat 2 of a 4-beat frame to port 0 -> next cycle all tvalid=0, FIFOs empty, state IDLE. A fresh frame after reset is routed correctly.
